// File: rtl/mem_stage_pkg.sv
// Shared bus widths and payload layouts for the memory-access stage.
// The execute->mem and mem->write-back buses are declared as packed structs, MSB first.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 71;
    localparam int MS_TO_WS_BUS_WD = 70;

    typedef struct packed {
        logic [31:0] pc;
        logic        load_op;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] alu_result;
    } es_to_ms_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] final_result;
    } ms_to_ws_bus_t;

endpackage

// File: rtl/sirv_gnrl_dfflr.sv
// Enable-loaded D flip-flop bank with asynchronous active-low reset to zero.
// Every state element of the mem stage is one instance of this module.
module sirv_gnrl_dfflr #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: merges the synchronous SRAM read word with the ALU result
// and hands it to write-back; a local buffer keeps load data alive across write-back stalls.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                cpu_data_rdata,
    output logic                       ms_to_ds_rf_we,
    output logic [4:0]                 ms_to_ds_rf_waddr,
    output logic [31:0]                ms_to_ds_rf_wdata
);

    localparam logic MS_READY_GO = 1'b1;

    logic                       ms_valid;
    logic                       ms_fresh;
    logic                       accept;
    logic [ES_TO_MS_BUS_WD-1:0] bus_q;
    logic [31:0]                rdata_buf;
    logic [31:0]                load_data;
    logic [31:0]                final_result;
    es_to_ms_bus_t              ms_fields;
    ms_to_ws_bus_t              ws_fields;

    assign ms_allowin = ~ms_valid | (MS_READY_GO & ws_allowin);
    assign accept     = ms_allowin & es_to_ms_valid;

    sirv_gnrl_dfflr #(.DW(1)) u_valid (
        .clk   (clk),
        .rst_n (reset),
        .lden  (ms_allowin),
        .dnxt  (es_to_ms_valid),
        .qout  (ms_valid)
    );

    // High only in the first cycle after acceptance, when the SRAM word is on the wire.
    sirv_gnrl_dfflr #(.DW(1)) u_fresh (
        .clk   (clk),
        .rst_n (reset),
        .lden  (1'b1),
        .dnxt  (accept),
        .qout  (ms_fresh)
    );

    sirv_gnrl_dfflr #(.DW(ES_TO_MS_BUS_WD)) u_bus (
        .clk   (clk),
        .rst_n (reset),
        .lden  (accept),
        .dnxt  (es_to_ms_bus),
        .qout  (bus_q)
    );

    // NOTE: the read buffer is cleared on reset so outputs are all-zero out of reset.
    sirv_gnrl_dfflr #(.DW(32)) u_rdata_buf (
        .clk   (clk),
        .rst_n (reset),
        .lden  (ms_fresh),
        .dnxt  (cpu_data_rdata),
        .qout  (rdata_buf)
    );

    assign ms_fields    = es_to_ms_bus_t'(bus_q);
    assign load_data    = ms_fresh ? cpu_data_rdata : rdata_buf;
    assign final_result = ms_fields.load_op ? load_data : ms_fields.alu_result;

    assign ws_fields.pc           = ms_fields.pc;
    assign ws_fields.rf_we        = ms_fields.rf_we;
    assign ws_fields.rf_waddr     = ms_fields.rf_waddr;
    assign ws_fields.final_result = final_result;

    assign ms_to_ws_valid = ms_valid & MS_READY_GO;
    assign ms_to_ws_bus   = ws_fields;

    assign ms_to_ds_rf_we    = ms_valid & ms_fields.rf_we;
    assign ms_to_ds_rf_waddr = ms_fields.rf_waddr;
    assign ms_to_ds_rf_wdata = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random traffic,
// every cycle compared against a slot-level reference model of the stage.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [31:0]                cpu_data_rdata;
    logic                       ms_to_ds_rf_we;
    logic [4:0]                 ms_to_ds_rf_waddr;
    logic [31:0]                ms_to_ds_rf_wdata;

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction sitting in the stage, how many cycles it has
    // been there, and the load word it picked up in its first cycle.
    bit                       m_valid;
    logic [ES_TO_MS_BUS_WD-1:0] m_instr;
    logic [31:0]              m_saved;
    int                       m_age;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .cpu_data_rdata    (cpu_data_rdata),
        .ms_to_ds_rf_we    (ms_to_ds_rf_we),
        .ms_to_ds_rf_waddr (ms_to_ds_rf_waddr),
        .ms_to_ds_rf_wdata (ms_to_ds_rf_wdata)
    );

    function automatic logic [70:0] mk(input logic [31:0] pc, input logic ld, input logic we,
                                       input logic [4:0] wa, input logic [31:0] alu);
        return {pc, ld, we, wa, alu};
    endfunction

    task automatic check(input string tag, input logic [70:0] got, input logic [70:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_instr = '0;
        m_saved = '0;
        m_age   = 1;
    endtask

    // Advance model and DUT by one rising edge using the inputs currently applied.
    task automatic tick();
        bit can_take;
        can_take = !m_valid || ws_allowin;
        if (m_age == 0) m_saved = cpu_data_rdata;
        if (m_age < 1000) m_age++;
        if (can_take) begin
            m_valid = es_to_ms_valid;
            if (es_to_ms_valid) begin
                m_instr = es_to_ms_bus;
                m_age   = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [70:0] bus, input logic [31:0] rd,
                         input logic ws);
        es_to_ms_valid = v;
        es_to_ms_bus   = bus;
        cpu_data_rdata = rd;
        ws_allowin     = ws;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] ld;
        logic [31:0] fin;
        #1;
        ld  = (m_age == 0) ? cpu_data_rdata : m_saved;
        fin = m_instr[38] ? ld : m_instr[31:0];
        check({tag, ".allowin"}, 71'(ms_allowin), 71'(!m_valid || ws_allowin));
        check({tag, ".ws_valid"}, 71'(ms_to_ws_valid), 71'(m_valid));
        check({tag, ".ws_bus"}, 71'(ms_to_ws_bus), 71'({m_instr[70:39], m_instr[37:32], fin}));
        check({tag, ".ds_we"}, 71'(ms_to_ds_rf_we), 71'(m_valid && m_instr[37]));
        check({tag, ".ds_waddr"}, 71'(ms_to_ds_rf_waddr), 71'(m_instr[36:32]));
        check({tag, ".ds_wdata"}, 71'(ms_to_ds_rf_wdata), 71'(fin));
    endtask

    initial begin
        drive(0, '0, '0, 1);
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        check("reset.allowin_one", 71'(ms_allowin), 71'(1));
        check("reset.bus_zero", 71'(ms_to_ws_bus), 71'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ALU op forwarded and handed off one cycle after acceptance
        drive(1, mk(32'h100, 0, 1, 5'd5, 32'h0000_1234), 32'h5555_AAAA, 1);
        tick();
        drive(0, '0, 32'h0, 1);
        check_model("alu");
        check("alu.final", 71'(ms_to_ws_bus[31:0]), 71'(32'h1234));
        check("alu.ds_we", 71'(ms_to_ds_rf_we), 71'(1));
        check("alu.ds_waddr", 71'(ms_to_ds_rf_waddr), 71'(5));
        tick();
        check_model("alu.drain");

        // Load with no stall: final result is the SRAM word in the fresh cycle
        drive(1, mk(32'h104, 1, 1, 5'd7, 32'h0000_0040), 32'h0, 1);
        tick();
        drive(0, '0, 32'hDEAD_BEEF, 1);
        check_model("ld");
        check("ld.final", 71'(ms_to_ws_bus[31:0]), 71'(32'hDEAD_BEEF));
        check("ld.handoff", 71'(ms_to_ws_valid && ms_allowin), 71'(1));
        tick();
        check("ld.gone", 71'(ms_to_ws_valid), 71'(0));

        // Load held under a 3-cycle write-back stall while the SRAM bus changes
        drive(1, mk(32'h108, 1, 1, 5'd9, 32'h0000_0080), 32'h0, 1);
        tick();
        drive(0, '0, 32'hCAFE_0001, 0);
        check_model("stall0");
        check("stall0.final", 71'(ms_to_ws_bus[31:0]), 71'(32'hCAFE_0001));
        for (int i = 1; i < 3; i++) begin
            tick();
            cpu_data_rdata = (i == 1) ? 32'h0 : 32'hFFFF_FFFF;
            check_model("stall");
            check("stall.final", 71'(ms_to_ws_bus[31:0]), 71'(32'hCAFE_0001));
            check("stall.held", 71'(ms_to_ws_valid && !ms_allowin), 71'(1));
        end
        tick();
        ws_allowin     = 1;
        cpu_data_rdata = 32'h0;
        check_model("stall.release");
        check("stall.release_final", 71'(ms_to_ws_bus[31:0]), 71'(32'hCAFE_0001));
        tick();
        check("stall.gone", 71'(ms_to_ws_valid), 71'(0));

        // Three back-to-back loads, zero bubbles
        drive(1, mk(32'h200, 1, 1, 5'd1, 32'h0), 32'h0, 1);
        tick();
        for (int i = 1; i <= 3; i++) begin
            if (i < 3) drive(1, mk(32'h200 + 32'(4 * i), 1, 1, 5'(i + 1), 32'h0), 32'(8'h11 * i), 1);
            else drive(0, '0, 32'h33, 1);
            check_model("b2b");
            check("b2b.final", 71'(ms_to_ws_bus[31:0]), 71'(32'(8'h11 * i)));
            check("b2b.valid", 71'(ms_to_ws_valid), 71'(1));
            tick();
        end
        check("b2b.drain", 71'(ms_to_ws_valid), 71'(0));

        // Store never forwards a write, valid drops after handoff
        drive(1, mk(32'h300, 0, 0, 5'd12, 32'h0000_1000), 32'h0, 1);
        tick();
        drive(0, '0, 32'h0, 1);
        check_model("st");
        check("st.ds_we", 71'(ms_to_ds_rf_we), 71'(0));
        check("st.valid", 71'(ms_to_ws_valid), 71'(1));
        tick();
        check("st.ds_we_after", 71'(ms_to_ds_rf_we), 71'(0));
        check("st.valid_after", 71'(ms_to_ws_valid), 71'(0));

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  mk($urandom, 1'($urandom), 1'($urandom), 5'($urandom), $urandom),
                  $urandom, 1'($urandom_range(0, 2) != 0));
            check_model("rand");
            tick();
        end

        // Asynchronous reset while a load is held in a stall
        drive(1, mk(32'h400, 1, 1, 5'd3, 32'h0), 32'h0, 1);
        tick();
        drive(0, '0, 32'h1357_9BDF, 0);
        tick();
        check("rst.held", 71'(ms_to_ws_valid), 71'(1));
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("rst.valid", 71'(ms_to_ws_valid), 71'(0));
        check("rst.allowin", 71'(ms_allowin), 71'(1));
        check("rst.bus", 71'(ms_to_ws_bus), 71'(0));
        check("rst.ds", 71'({ms_to_ds_rf_we, ms_to_ds_rf_waddr, ms_to_ds_rf_wdata}), 71'(0));
        check_model("rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
